// File: rtl/osbm_arb_pkg.sv
// router_pkg: shared definitions for the router output-side arbiter.
//   - flit-type encodings carried on the per-input ptype legs
//   - arbiter state enum (also exported on the debug port)
//   - default number of input ports
package router_pkg;

  localparam int N_DEF = 4;

  // Flit types. 2'b11 is reserved and behaves like BODY: only TAIL ends a packet.
  localparam logic [1:0] BODY = 2'b00;
  localparam logic [1:0] TAIL = 2'b01;
  localparam logic [1:0] HEAD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    XFER = 2'd2
  } arb_state_e;

endpackage

// File: rtl/osbm_arb_if.sv
// osbm_arb_if: bundle between the N input-side buffer managers / output FIFO
// (master side) and one output-port arbiter (slave side).
//   req   [N]    request for this output port, one bit per input
//   vld   [N]    per-input flit present on its crossbar leg this cycle
//   ptype [2N]   per-input flit type, bits [2i+1:2i] belong to input i
//   ofull        output FIFO full
//   ack   [N]    one-hot grant pulse
//   sel   [SW]   crossbar select (granted input index)
//   owe          output FIFO write enable
//   busy         output port owned by a packet
//   err          sticky timeout flag
//
// Handshake: req is a level request with no ready back-pressure. The arbiter
// answers with a single-cycle one-hot ack; in that same cycle the granted
// manager presents its first flit (vld) and the arbiter writes it (owe).
// From then on each cycle with vld[sel]=1 is exactly one flit write, with no
// stall, until a TAIL flit is written. ofull only gates new grants.
interface osbm_arb_if #(
  parameter int N  = 4,
  parameter int SW = $clog2(N)
);
  logic [N-1:0]   req;
  logic [N-1:0]   vld;
  logic [2*N-1:0] ptype;
  logic           ofull;
  logic [N-1:0]   ack;
  logic [SW-1:0]  sel;
  logic           owe;
  logic           busy;
  logic           err;

  modport master (
    output req, vld, ptype, ofull,
    input  ack, sel, owe, busy, err
  );

  modport slave (
    input  req, vld, ptype, ofull,
    output ack, sel, owe, busy, err
  );
endinterface

// File: rtl/osbm_arb_rr_pick.sv
// rr_pick: combinational round-robin priority pick.
//   i_req    [N]   request vector
//   i_ptr    [SW]  highest-priority index this round
//   o_winner [SW]  first set request searching from i_ptr upward, wrapping
//   o_found        at least one request set
module rr_pick #(
  parameter int N  = 4,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [SW-1:0] i_ptr,
  output logic [SW-1:0] o_winner,
  output logic          o_found
);

  logic [SW:0]   w_sum;
  logic [SW-1:0] w_idx;

  // Scan offsets from farthest to nearest; the last hit written is the one
  // closest to i_ptr, so no early exit is needed.
  always_comb begin
    o_winner = '0;
    o_found  = 1'b0;
    w_sum    = '0;
    w_idx    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_sum = {1'b0, i_ptr} + (SW+1)'(k);
      if (w_sum >= (SW+1)'(N)) begin
        w_sum = w_sum - (SW+1)'(N);
      end
      w_idx = w_sum[SW-1:0];
      if (i_req[w_idx]) begin
        o_winner = w_idx;
        o_found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/osbm_arb.sv
// osbm_arb: output-side round-robin arbiter for one router output port.
// Grants one requesting input at a time, holds the crossbar select until that
// packet's TAIL flit is written, and drives the output FIFO write enable.
// A granted input that stops sending for TMO consecutive cycles is forcibly
// released and the sticky err flag is raised.
//   clk          rising-edge clock
//   rst          asynchronous reset, active-low
//   bus          osbm_arb_if slave modport (req/vld/ptype/ofull in,
//                ack/sel/owe/busy/err out)
//   o_dbg_state  current arbiter state
module osbm_arb
  import router_pkg::*;
#(
  parameter int N   = N_DEF,
  parameter int SW  = $clog2(N),
  parameter int TMO = 16          // must be >= 2
) (
  input  logic       clk,
  input  logic       rst,
  osbm_arb_if.slave  bus,
  output arb_state_e o_dbg_state
);

  localparam int CW = $clog2(TMO + 1);

  arb_state_e    r_state, w_state_nxt;
  logic [SW-1:0] r_ptr, w_ptr_nxt;
  logic [SW-1:0] r_sel, w_sel_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_err, w_err_nxt;

  logic [SW-1:0] w_winner;
  logic          w_found;
  logic          w_vld_sel;
  logic [1:0]    w_pt_sel;
  logic          w_tail;
  logic [N-1:0]  w_ack;
  logic          w_owe;
  logic          w_busy;

  rr_pick #(.N(N), .SW(SW)) u_pick (
    .i_req    (bus.req),
    .i_ptr    (r_ptr),
    .o_winner (w_winner),
    .o_found  (w_found)
  );

  // Only the selected leg matters; other inputs' vld/ptype are ignored.
  assign w_vld_sel = bus.vld[r_sel];
  assign w_pt_sel  = bus.ptype[{r_sel, 1'b0} +: 2];
  assign w_tail    = w_vld_sel && (w_pt_sel == TAIL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_sel   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_sel   <= w_sel_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_sel_nxt   = r_sel;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
    w_ack       = '0;
    w_owe       = 1'b0;
    w_busy      = 1'b0;

    unique case (r_state)
      IDLE: begin
        // ofull is only consulted here: a granted packet is never throttled.
        if (w_found && !bus.ofull) begin
          w_sel_nxt   = w_winner;
          w_ptr_nxt   = (w_winner == SW'(N - 1)) ? '0 : w_winner + 1'b1;
          w_state_nxt = ACK;
        end
      end
      ACK: begin
        w_ack[r_sel] = 1'b1;
        w_busy       = 1'b1;
        w_owe        = w_vld_sel;
        w_cnt_nxt    = '0;
        w_state_nxt  = w_tail ? IDLE : XFER;
      end
      XFER: begin
        w_busy = 1'b1;
        w_owe  = w_vld_sel;
        if (w_tail) begin
          w_state_nxt = IDLE;
        end else if (!w_vld_sel) begin
          if (r_cnt >= CW'(TMO - 1)) begin
            w_cnt_nxt   = CW'(TMO);
            w_err_nxt   = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end else begin
          w_cnt_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.ack     = w_ack;
  assign bus.sel     = r_sel;
  assign bus.owe     = w_owe;
  assign bus.busy    = w_busy;
  assign bus.err     = r_err;
  assign o_dbg_state = r_state;

endmodule
